// File: rtl/booth_r4_seq_mult.sv
// Iterative signed radix-4 Booth multiplier: one recoded window is added per cycle through a 2*WIDTH ripple adder.
// Latency: out_valid rises WIDTH/2 edges after the accepting edge; one product per WIDTH/2+2 cycles.
// Backpressure: DONE holds product/out_valid until out_ready; in_ready is low outside IDLE.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = 2 * WIDTH;
    localparam int NITER = WIDTH / 2;
    localparam int CW    = $clog2(NITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    // a_q holds the sign-extended multiplicand already shifted by 2*count,
    // m_q holds {b,0} shifted right by 2*count so the live window is m_q[2:0].
    logic [PW-1:0]   a_q, a_d;
    logic [WIDTH:0]  m_q, m_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;

    logic            neg;
    logic            one;
    logic            two;
    logic [PW-1:0]   opnd;
    logic            cin;
    logic [PW-1:0]   sum;

    // Booth recode of the current window into 0 / +-A / +-2A, negation as invert plus carry-in.
    always_comb begin
        neg = 1'b0;
        one = 1'b0;
        two = 1'b0;
        case (m_q[2:0])
            3'b001, 3'b010: one = 1'b1;
            3'b011:         two = 1'b1;
            3'b100:         begin two = 1'b1; neg = 1'b1; end
            3'b101, 3'b110: begin one = 1'b1; neg = 1'b1; end
            default:        ;
        endcase
        if (two) begin
            opnd = a_q << 1;
        end else if (one) begin
            opnd = a_q;
        end else begin
            opnd = '0;
        end
        if (neg) begin
            opnd = ~opnd;
        end
        cin = neg;
    end

    // Ripple-carry add of accumulator and partial product; carry-out is dropped (mod 2^PW).
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < PW; i++) begin
            sum[i] = acc_q[i] ^ opnd[i] ^ carry;
            carry  = (acc_q[i] & opnd[i]) | (acc_q[i] & carry) | (opnd[i] & carry);
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = {{WIDTH{a[WIDTH-1]}}, a};
                    m_d     = {b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = sum;
                a_d   = a_q << 2;
                m_d   = m_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NITER - 1)) begin
                    prod_d  = sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and random checks of the radix-4 Booth sequential multiplier (WIDTH=8).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected products are hand constants or computed from signed integer multiply.
module tb_booth_r4_seq_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    booth_r4_seq_mult #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[15:0];
    endfunction

    // Issue one operand pair, check latency and product, stall the output, then hand it off.
    task automatic do_mult(input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] exp, input int stall, input string tag);
        int g;
        int lat;
        g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        a = av; b = bv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check({tag, "_latency"}, 32'(lat), 32'(4));
        check({tag, "_product"}, 32'(product), 32'(exp));
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_stall_valid"}, 32'(out_valid), 32'(1));
            check({tag, "_stall_prod"}, 32'(product), 32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_post_ready"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        int g;
        int lat;
        int prev_acc;
        int received;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'(1));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_product",   32'(product),   32'(0));

        // Basic and corner-case products.
        do_mult(8'd3,    8'd5,    16'h000F, 0, "p3x5");
        do_mult(8'h80,   8'h80,   16'h4000, 0, "pm128xm128");
        do_mult(8'h80,   8'h7F,   16'hC080, 0, "pm128x127");
        do_mult(8'h7F,   8'h7F,   16'h3F01, 0, "p127x127");
        do_mult(8'hFF,   8'h01,   16'hFFFF, 0, "pm1x1");
        do_mult(8'h00,   8'h80,   16'h0000, 1, "p0xm128");

        // Backpressure: held result, ignored in_valid while DONE.
        a = 8'd6; b = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check("bp_latency", 32'(lat), 32'(4));
        a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_product",   32'(product),   32'(16'h002A));
            check("bp_in_ready",  32'(in_ready),  32'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready), 32'(1));
        check("bp_release_valid", 32'(out_valid), 32'(0));
        check("bp_hold_product",  32'(product),  32'(16'h002A));
        for (int s = 0; s < 6; s++) begin
            tick();
            check("bp_no_ghost", 32'(out_valid), 32'(0));
        end

        // Reset mid-RUN aborts without an output pulse.
        a = 8'd9; b = 8'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid",   32'(out_valid), 32'(0));
        check("rst_mid_ready",   32'(in_ready),  32'(1));
        check("rst_mid_product", 32'(product),   32'(0));
        for (int s = 0; s < 6; s++) begin
            tick();
            check("rst_mid_no_pulse", 32'(out_valid), 32'(0));
        end
        do_mult(8'd2, 8'hFD, 16'hFFFA, 0, "p2xm3");

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; out_ready = 1'b1; prev_acc = 0;
        for (int k = 0; k < 10; k++) begin
            g = 0;
            while (!in_ready && g < 20) begin tick(); g++; end
            ra = 8'($urandom); rb = 8'($urandom);
            e = ref_mul(ra, rb);
            a = ra; b = rb;
            tick();
            if (k > 0) check("b2b_spacing", 32'(cyc - prev_acc), 32'(6));
            prev_acc = cyc;
            a = 8'($urandom); b = 8'($urandom);
            lat = 0;
            while (!out_valid && lat < 20) begin tick(); lat++; end
            check("b2b_latency", 32'(lat), 32'(4));
            check("b2b_product", 32'(product), 32'(e));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("b2b_tail_idle", 32'(out_valid), 32'(0));

        // Random sweep with random output stalls and idle gaps.
        received = 0;
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            e = ref_mul(ra, rb);
            g = 0;
            while (!in_ready && g < 20) begin tick(); g++; end
            a = ra; b = rb; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                out_ready = 1'b0;
                tick();
                lat++;
            end
            if (out_valid) received++;
            check("rnd_product", 32'(product), 32'(e));
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
                tick();
                check("rnd_stall_prod", 32'(product), 32'(e));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("rnd_no_dup", 32'(out_valid), 32'(0));
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) tick();
        end
        check("rnd_received", 32'(received), 32'(1000));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
